// File: rtl/xadc_drp_responder.sv
// Behavioural XADC DRP slave for simulation builds: 128x16 register space with a
// read-only status half, a read/write config half and a free-running conversion timer.
module xadc_drp_responder #(
  parameter int unsigned LATENCY     = 4,
  parameter int unsigned CONV_PERIOD = 1000,
  parameter logic [15:0] TEMP_INIT   = 16'h9A00,
  parameter logic [15:0] CFG42_INIT  = 16'h0400
) (
  input  logic        clock_i,
  input  logic        reset_n_i,
  input  logic        den_i,
  input  logic        dwe_i,
  input  logic [6:0]  daddr_i,
  input  logic [15:0] di_i,
  output logic [15:0] do_o,
  output logic        drdy_o,
  output logic        busy_o,
  output logic        eoc_o,
  output logic        protocol_err_o
);

  localparam int unsigned   CW        = $clog2(CONV_PERIOD);
  localparam logic [CW-1:0] CONV_LAST = CW'(CONV_PERIOD - 1);
  localparam logic [3:0]    LAT_LOAD  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    lat_q, lat_d;
  logic [6:0]    addr_q, addr_d;
  logic [15:0]   data_q, data_d;
  logic          we_q, we_d;
  logic          err_q, err_d;
  logic [15:0]   do_q, do_d;
  logic          drdy, busy, cfg_we;
  logic [15:0]   rd_data;
  logic [CW-1:0] conv_q;
  // Only the low nibble of the sample counter is ever observable, so only it is stored.
  logic [3:0]    samp_q;
  logic [15:0]   cfg_q [64];

  // Conversion timer, independent of DRP traffic.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      conv_q <= '0;
      samp_q <= '0;
    end else if (conv_q == CONV_LAST) begin
      conv_q <= '0;
      samp_q <= samp_q + 4'd1;
    end else begin
      conv_q <= conv_q + 1'b1;
    end
  end

  assign eoc_o = (conv_q == CONV_LAST);

  // Evaluated in the RESP cycle, so status reads see the pre-increment sample count.
  always_comb begin
    rd_data = '0;
    if (addr_q[6]) begin
      rd_data = cfg_q[addr_q[5:0]];
    end else if (addr_q == 7'h00) begin
      rd_data = TEMP_INIT + {12'b0, samp_q};
    end else if (addr_q == 7'h3F) begin
      rd_data = {12'b0, samp_q};
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      lat_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      do_q    <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      err_q   <= err_d;
      do_q    <= do_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = we_q;
    err_d   = err_q;
    do_d    = do_q;
    drdy    = 1'b0;
    busy    = 1'b0;
    cfg_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (den_i) begin
          addr_d  = daddr_i;
          data_d  = di_i;
          we_d    = dwe_i;
          lat_d   = LAT_LOAD;
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (den_i) err_d = 1'b1;
        lat_d = lat_q - 4'd1;
        if (lat_q <= 4'd1) state_d = RESP;
      end
      RESP: begin
        drdy = 1'b1;
        if (den_i) err_d = 1'b1;
        if (!we_q) begin
          do_d = rd_data;
        end else if (addr_q[6]) begin
          cfg_we = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int unsigned i = 0; i < 64; i++) begin
        cfg_q[6'(i)] <= (i == 2) ? CFG42_INIT : '0;
      end
    end else if (cfg_we) begin
      cfg_q[addr_q[5:0]] <= data_q;
    end
  end

  // do_d equals do_q except in a read RESP cycle, giving valid data alongside drdy.
  assign do_o           = do_d;
  assign drdy_o         = drdy;
  assign busy_o         = busy;
  assign protocol_err_o = err_q;

endmodule
